issue_unit: RTL

Tomasulo issue stage sitting directly downstream of the instruction decoder: accepts one decoded instruction per cycle, allocates a free ALU or memory reservation station, renames sources through a register status table (RAT), and presents a registered issue packet to the reservation stations. It also snoops the common data bus (CDB) to release stations and clear RAT entries.

---
 rtl/issue_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/issue_unit.sv
// Tomasulo issue stage: allocates a reservation station, renames sources through the
// register status table, and emits a registered issue packet while snooping the CDB.
module issue_unit #(
  parameter int NUM_ALU_RS = 3,
  parameter int NUM_MEM_RS = 2,
  parameter int TAG_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_valid,
  input  logic                  mem,
  input  logic                  mul,
  input  logic                  lwSw,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [4:0]            rd,
  input  logic                  inactive,
  output logic                  inst_ready,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  output logic                  issue_valid,
  output logic [TAG_W-1:0]      issue_tag,
  output logic [TAG_W-1:0]      issue_qj,
  output logic [TAG_W-1:0]      issue_qk,
  output logic [4:0]            issue_rs1,
  output logic [4:0]            issue_rs2,
  output logic [4:0]            issue_rd,
  output logic                  issue_is_mem,
  output logic                  issue_is_load,
  output logic                  issue_mul,
  output logic [NUM_ALU_RS-1:0] alu_busy,
  output logic [NUM_MEM_RS-1:0] mem_busy
);

  localparam int NUM_RS = NUM_ALU_RS + NUM_MEM_RS;

  logic [NUM_RS-1:0] r_busy;
  logic [TAG_W-1:0]  r_rat [32];
  logic              r_issue_valid;
  logic [TAG_W-1:0]  r_issue_tag, r_issue_qj, r_issue_qk;
  logic [4:0]        r_issue_rs1, r_issue_rs2, r_issue_rd;
  logic              r_issue_is_mem, r_issue_is_load, r_issue_mul;

  logic              w_cls_alu, w_cls_mem, w_is_load;
  logic              w_alloc_found;
  logic [TAG_W-1:0]  w_alloc_tag;
  logic              w_issue, w_writes_rd, w_cdb_hit;
  logic [TAG_W-1:0]  w_qj, w_qk;
  logic [NUM_RS-1:0] w_busy_next;
  logic [TAG_W-1:0]  w_rat_next [32];

  assign w_cls_mem = mem & ~inactive;
  assign w_cls_alu = ~mem & ~inactive;
  assign w_is_load = mem & lwSw;

  // Descending scan so the lowest free index of the requested class wins.
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_tag   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!r_busy[i] && ((i < NUM_ALU_RS) ? w_cls_alu : w_cls_mem)) begin
        w_alloc_found = 1'b1;
        w_alloc_tag   = TAG_W'(i + 1);
      end
    end
  end

  assign inst_ready  = inactive | w_alloc_found;
  assign w_issue     = inst_valid & inst_ready & ~inactive;
  assign w_writes_rd = w_issue & (~mem | lwSw) & (rd != 5'd0);
  assign w_cdb_hit   = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_W'(NUM_RS));

  assign w_qj = ((rs1 == 5'd0) || (cdb_valid && r_rat[rs1] == cdb_tag)) ? '0 : r_rat[rs1];
  assign w_qk = ((rs2 == 5'd0) || w_is_load || (cdb_valid && r_rat[rs2] == cdb_tag)) ? '0 : r_rat[rs2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : g_busy
      assign w_busy_next[gi] = (w_issue && w_alloc_tag == TAG_W'(gi + 1)) |
                               (r_busy[gi] & ~(w_cdb_hit && cdb_tag == TAG_W'(gi + 1)));
    end
    // The issue write to rd takes priority over a same-cycle CDB clear.
    for (gi = 0; gi < 32; gi++) begin : g_rat
      assign w_rat_next[gi] = (w_writes_rd && rd == 5'(gi)) ? w_alloc_tag :
                              (w_cdb_hit && r_rat[gi] == cdb_tag) ? '0 : r_rat[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < 32; i++) r_rat[i] <= '0;
    end else begin
      r_busy <= w_busy_next;
      for (int i = 0; i < 32; i++) r_rat[i] <= w_rat_next[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issue_valid   <= 1'b0;
      r_issue_tag     <= '0;
      r_issue_qj      <= '0;
      r_issue_qk      <= '0;
      r_issue_rs1     <= '0;
      r_issue_rs2     <= '0;
      r_issue_rd      <= '0;
      r_issue_is_mem  <= 1'b0;
      r_issue_is_load <= 1'b0;
      r_issue_mul     <= 1'b0;
    end else begin
      r_issue_valid <= w_issue;
      if (w_issue) begin
        r_issue_tag     <= w_alloc_tag;
        r_issue_qj      <= w_qj;
        r_issue_qk      <= w_qk;
        r_issue_rs1     <= rs1;
        r_issue_rs2     <= rs2;
        r_issue_rd      <= rd;
        r_issue_is_mem  <= mem;
        r_issue_is_load <= w_is_load;
        r_issue_mul     <= mul;
      end
    end
  end

  assign issue_valid   = r_issue_valid;
  assign issue_tag     = r_issue_tag;
  assign issue_qj      = r_issue_qj;
  assign issue_qk      = r_issue_qk;
  assign issue_rs1     = r_issue_rs1;
  assign issue_rs2     = r_issue_rs2;
  assign issue_rd      = r_issue_rd;
  assign issue_is_mem  = r_issue_is_mem;
  assign issue_is_load = r_issue_is_load;
  assign issue_mul     = r_issue_mul;
  assign alu_busy      = r_busy[NUM_ALU_RS-1:0];
  assign mem_busy      = r_busy[NUM_RS-1:NUM_ALU_RS];

endmodule
